// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one byte-wide SPI master
// engine; holds a per-slave select across a whole burst, with a watchdog.
module spi_txn_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [8*NUM_REQ-1:0]   req_tx_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     byte_ack,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   err_timeout,
    output logic [NUM_REQ-1:0]     ss_n,
    output logic                   m_start,
    output logic [7:0]             m_tx_data,
    input  logic [7:0]             m_rx_data,
    input  logic                   m_done,
    output logic                   busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [NUM_REQ-1:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE,
        GAP
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            found;
    logic            last_q;
    logic [WW-1:0]   wdog;
    logic [WW-1:0]   wdog_inc;
    logic [GW-1:0]   gap_cnt;

    // Scan downward in offset so the nearest requester after ptr wins last.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = PW'((int'(ptr) + off) % NUM_REQ);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign wdog_inc = wdog + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= PW'(NUM_REQ - 1);
            owner       <= '0;
            last_q      <= 1'b0;
            wdog        <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            byte_ack    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_timeout <= 1'b0;
            ss_n        <= '1;
            m_start     <= 1'b0;
            m_tx_data   <= '0;
            busy        <= 1'b0;
        end else begin
            m_start     <= 1'b0;
            byte_ack    <= '0;
            rx_valid    <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant <= ONE << pick;
                        ss_n  <= ~(ONE << pick);
                        owner <= pick;
                        ptr   <= pick;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start   <= 1'b1;
                    m_tx_data <= req_tx_data[{owner, 3'b000} +: 8];
                    last_q    <= req_last[owner];
                    wdog      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        rx_data  <= m_rx_data;
                        rx_valid <= 1'b1;
                        byte_ack <= grant;
                        state    <= (last_q || !req[owner]) ? RELEASE : ISSUE;
                    end else if (wdog_inc == WW'(TIMEOUT - 1)) begin
                        // abort lands TIMEOUT cycles after the ISSUE cycle
                        err_timeout <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                RELEASE: begin
                    ss_n    <= '1;
                    grant   <= '0;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with an engine model and
// requester model driven from one process at the falling clock edge.
module tb_spi_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_tx_data = '0;
    logic [3:0]  grant, byte_ack, ss_n;
    logic [7:0]  rx_data, m_tx_data;
    logic        rx_valid, err_timeout, m_start, busy;
    logic [7:0]  m_rx_data = '0;
    logic        m_done = 1'b0;

    spi_txn_arbiter #(.NUM_REQ(4), .GAP_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last),
        .req_tx_data(req_tx_data), .grant(grant), .byte_ack(byte_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .err_timeout(err_timeout),
        .ss_n(ss_n), .m_start(m_start), .m_tx_data(m_tx_data),
        .m_rx_data(m_rx_data), .m_done(m_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // observation statistics
    int cyc, n_start, n_rx, n_err, err_cyc, grant_cyc;
    int ss_rise, ss0_low, gap_hi, inv_bad;
    int n_ack [4];
    logic [7:0] tx_log [$];
    logic [7:0] rx_log [$];
    logic [3:0] grant_log [$];
    logic [3:0] prev_grant = '0;
    logic [3:0] prev_ss = '1;

    // engine model: rx byte = tx byte ^ 8'h99
    int   eng_lat = 3;
    bit   eng_hang = 0;
    bit   eng_act = 0;
    int   eng_cnt = 0;
    logic [7:0] eng_tx = '0;

    // requester model
    logic [7:0] rq_bytes [4][8];
    int  rq_n [4];
    int  rq_pos [4];
    bit  rq_hold [4];

    bit ok;

    task automatic clear_stats();
        cyc = 0; n_start = 0; n_rx = 0; n_err = 0; err_cyc = -1;
        grant_cyc = -1; ss_rise = 0; ss0_low = 0; gap_hi = 0; inv_bad = 0;
        for (int i = 0; i < 4; i++) n_ack[i] = 0;
        tx_log.delete(); rx_log.delete(); grant_log.delete();
    endtask

    task automatic arm(input int i, input int n, input bit hold);
        rq_n[i] = n; rq_pos[i] = 0; rq_hold[i] = hold;
        req_tx_data[8*i +: 8] = rq_bytes[i][0];
        req_last[i] = hold || (n == 1);
        req[i] = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (m_start) begin n_start++; tx_log.push_back(m_tx_data); end
        if (rx_valid) begin n_rx++; rx_log.push_back(rx_data); end
        for (int i = 0; i < 4; i++) if (byte_ack[i]) n_ack[i]++;
        if (err_timeout) begin n_err++; err_cyc = cyc; end
        if (grant != 0 && prev_grant == 0) begin
            grant_log.push_back(grant); grant_cyc = cyc;
        end
        if (ss_n == 4'hF && prev_ss != 4'hF) ss_rise++;
        if (!ss_n[0]) ss0_low++;
        if (busy && ss_n == 4'hF) gap_hi++;
        if (!$onehot0(grant) || ss_n != ~grant || (byte_ack & ~grant) != 0)
            inv_bad++;
        prev_grant = grant; prev_ss = ss_n;
        m_done = 1'b0;
        if (rst) begin
            eng_act = 0;
        end else if (m_start) begin
            eng_act = 1; eng_cnt = eng_lat; eng_tx = m_tx_data;
        end else if (eng_act) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_act = 0;
                if (!eng_hang) begin
                    m_done = 1'b1; m_rx_data = eng_tx ^ 8'h99;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (byte_ack[i] && !rq_hold[i]) begin
                rq_pos[i]++;
                if (rq_pos[i] >= rq_n[i]) req[i] = 1'b0;
            end
            if (rq_pos[i] < 8) req_tx_data[8*i +: 8] = rq_bytes[i][rq_pos[i]];
            req_last[i] = rq_hold[i] || (rq_pos[i] == rq_n[i] - 1);
        end
    endtask

    task automatic wait_idle(input int max, output bit done);
        bit saw = 0;
        for (int t = 0; t < max; t++) begin
            step();
            if (busy) saw = 1;
            else if (saw) break;
        end
        done = saw && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++; if (grant !== 4'h0) begin bad++; $display("FAIL reset_grant got %h want 0", grant); end
        total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL reset_ss_n got %h want f", ss_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (m_start !== 1'b0 || m_tx_data !== 8'h00) begin bad++; $display("FAIL reset_engine got %b/%h want 0/00", m_start, m_tx_data); end
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got %b/%h want 0/00", rx_valid, rx_data); end
        total++; if ({byte_ack, err_timeout} !== 5'h0) begin bad++; $display("FAIL reset_pulses got %h want 0", {byte_ack, err_timeout}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [6];
        exp_g = '{4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8};
        clear_stats();
        eng_lat = 2; eng_hang = 0;
        rq_bytes[0][0] = 8'h10; rq_bytes[1][0] = 8'h20; rq_bytes[3][0] = 8'h30;
        arm(0, 1, 1); arm(1, 1, 1); arm(3, 1, 1);
        for (int t = 0; t < 400 && grant_log.size() < 6; t++) step();
        req = '0; rq_hold = '{0, 0, 0, 0};
        wait_idle(100, ok);
        total++; if (!ok || grant_log.size() != 6) begin bad++; $display("FAIL contention_count got %0d want 6", grant_log.size()); end
        for (int j = 0; j < 6 && j < grant_log.size(); j++) begin
            total++;
            if (grant_log[j] !== exp_g[j]) begin bad++; $display("FAIL contention_order[%0d] got %h want %h", j, grant_log[j], exp_g[j]); end
        end
        total++; if (inv_bad != 0) begin bad++; $display("FAIL contention_onehot got %0d want 0", inv_bad); end
    endtask

    task automatic test_single();
        clear_stats();
        eng_lat = 19; eng_hang = 0;
        rq_bytes[0][0] = 8'hA5;
        arm(0, 1, 0);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done got busy=%b want 0", busy); end
        total++; if (n_start != 1 || tx_log.size() < 1 || tx_log[0] !== 8'hA5) begin bad++; $display("FAIL single_start got %0d starts want 1 with a5", n_start); end
        total++; if (n_rx != 1 || rx_log.size() < 1 || rx_log[0] !== 8'h3C) begin bad++; $display("FAIL single_rx got %0d bytes want 1 with 3c", n_rx); end
        total++; if (n_ack[0] != 1) begin bad++; $display("FAIL single_ack got %0d want 1", n_ack[0]); end
        total++; if (ss0_low != 22) begin bad++; $display("FAIL single_ss_low got %0d want 22", ss0_low); end
        total++; if (gap_hi != 2) begin bad++; $display("FAIL single_gap got %0d want 2", gap_hi); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_tx [3];
        logic [7:0] exp_rx [3];
        exp_tx = '{8'h11, 8'h22, 8'h33};
        exp_rx = '{8'h88, 8'hBB, 8'hAA};
        clear_stats();
        eng_lat = 3;
        rq_bytes[2][0] = 8'h11; rq_bytes[2][1] = 8'h22; rq_bytes[2][2] = 8'h33;
        arm(2, 3, 0);
        wait_idle(200, ok);
        total++; if (!ok || n_start != 3 || n_rx != 3) begin bad++; $display("FAIL burst_count got %0d/%0d want 3/3", n_start, n_rx); end
        for (int j = 0; j < 3 && j < tx_log.size() && j < rx_log.size(); j++) begin
            total++;
            if (tx_log[j] !== exp_tx[j] || rx_log[j] !== exp_rx[j]) begin
                bad++; $display("FAIL burst_byte[%0d] got %h/%h want %h/%h", j, tx_log[j], rx_log[j], exp_tx[j], exp_rx[j]);
            end
        end
        total++; if (ss_rise != 1 || grant_log.size() != 1) begin bad++; $display("FAIL burst_release got %0d/%0d want 1/1", ss_rise, grant_log.size()); end
        total++; if (n_ack[2] != 3) begin bad++; $display("FAIL burst_ack got %0d want 3", n_ack[2]); end
    endtask

    task automatic test_watchdog();
        clear_stats();
        eng_hang = 1;
        rq_bytes[3][0] = 8'h5A;
        arm(3, 1, 0);
        wait_idle(300, ok);
        req[3] = 1'b0; rq_n[3] = 0;
        total++; if (!ok || n_err != 1) begin bad++; $display("FAIL wdog_err got %0d want 1", n_err); end
        total++; if (err_cyc - grant_cyc != 64) begin bad++; $display("FAIL wdog_time got %0d want 64", err_cyc - grant_cyc); end
        total++; if (n_rx != 0 || n_ack[3] != 0) begin bad++; $display("FAIL wdog_rx got %0d/%0d want 0/0", n_rx, n_ack[3]); end
        total++; if (ss_rise != 1 || ss_n !== 4'hF) begin bad++; $display("FAIL wdog_release got %0d/%h want 1/f", ss_rise, ss_n); end
        clear_stats();
        eng_hang = 0;
        rq_bytes[1][0] = 8'h77;
        arm(1, 1, 0);
        wait_idle(200, ok);
        total++; if (!ok || n_rx != 1 || rx_log.size() < 1 || rx_log[0] !== 8'hEE) begin bad++; $display("FAIL wdog_next got %0d bytes want 1 with ee", n_rx); end
        total++; if (grant_log.size() != 1 || grant_log[0] !== 4'h2) begin bad++; $display("FAIL wdog_next_grant got %0d grants want one 2", grant_log.size()); end
    endtask

    task automatic test_drop();
        clear_stats();
        eng_lat = 4;
        for (int j = 0; j < 4; j++) rq_bytes[1][j] = 8'h40 + 8'(j);
        arm(1, 4, 0);
        for (int t = 0; t < 200 && n_start < 2; t++) step();
        req[1] = 1'b0;
        wait_idle(200, ok);
        total++; if (!ok || n_start != 2) begin bad++; $display("FAIL drop_starts got %0d want 2", n_start); end
        total++; if (n_ack[1] != 2 || n_rx != 2) begin bad++; $display("FAIL drop_acks got %0d/%0d want 2/2", n_ack[1], n_rx); end
        total++; if (rx_log.size() < 2 || rx_log[1] !== 8'hD8) begin bad++; $display("FAIL drop_rx got %0d bytes want 2nd d8", rx_log.size()); end
        total++; if (ss_rise != 1) begin bad++; $display("FAIL drop_release got %0d want 1", ss_rise); end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        eng_lat = 10;
        rq_bytes[0][0] = 8'h01; rq_bytes[0][1] = 8'h02; rq_bytes[0][2] = 8'h03;
        arm(0, 3, 0);
        for (int t = 0; t < 100 && n_start < 1; t++) step();
        step(); step(); step();
        total++; if (busy !== 1'b1 || ss_n !== 4'hE) begin bad++; $display("FAIL mid_pre got %b/%h want 1/e", busy, ss_n); end
        rst = 1'b1;
        #1;
        total++; if (ss_n !== 4'hF || grant !== 4'h0) begin bad++; $display("FAIL mid_async got %h/%h want f/0", ss_n, grant); end
        total++; if (busy !== 1'b0 || m_start !== 1'b0) begin bad++; $display("FAIL mid_async_busy got %b/%b want 0/0", busy, m_start); end
        req = '0;
        for (int i = 0; i < 4; i++) begin rq_n[i] = 0; rq_pos[i] = 0; end
        step(); step();
        rst = 1'b0;
        step();
        clear_stats();
        eng_lat = 2;
        rq_bytes[0][0] = 8'hC0; rq_bytes[1][0] = 8'hC1;
        arm(0, 1, 0); arm(1, 1, 0);
        for (int t = 0; t < 200 && grant_log.size() < 2; t++) step();
        wait_idle(100, ok);
        total++; if (grant_log.size() < 1 || grant_log[0] !== 4'h1) begin bad++; $display("FAIL mid_first_grant got %0d grants want first 1", grant_log.size()); end
        total++; if (!ok || grant_log.size() != 2 || grant_log[1] !== 4'h2) begin bad++; $display("FAIL mid_second_grant got %0d grants want second 2", grant_log.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rq_n[i] = 0; rq_pos[i] = 0; rq_hold[i] = 0;
            for (int j = 0; j < 8; j++) rq_bytes[i][j] = '0;
        end
        clear_stats();
        test_reset();
        test_contention();
        test_single();
        test_burst();
        test_watchdog();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
